// File: rtl/pim_gemm_sched.sv
// Bit-serial GEMM column scheduler for a PIM crossbar: issues SLICE_BITS input bits per
// column, shift-accumulates the ADC samples and hands each column result out over valid/ready.
module pim_gemm_sched #(
    parameter  int unsigned DEPTH      = 100,
    parameter  int unsigned ADDR_W     = 7,
    parameter  int unsigned SLICE_BITS = 8,
    parameter  int unsigned ADC_P      = 8,
    parameter  int unsigned OUT_P      = 16,
    parameter  int unsigned ADC_LAT    = 1,
    localparam int unsigned BIT_W      = (SLICE_BITS > 1) ? $clog2(SLICE_BITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] xbar_addr,
    output logic [BIT_W-1:0]  bit_sel,
    output logic              xbar_en,
    input  logic [ADC_P-1:0]  adc_result,
    output logic [OUT_P-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned LAT_W = (ADC_LAT > 1) ? $clog2(ADC_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        EMIT   = 3'd3,
        FINISH = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [LAT_W-1:0]  drain_q, drain_d;
    logic [OUT_P-1:0]  acc_q, acc_d;

    // Issue tracking: which bit index each in-flight ADC sample belongs to
    logic [ADC_LAT-1:0] vld_q, vld_d;
    logic [BIT_W-1:0]   bpipe_q [ADC_LAT];
    logic [BIT_W-1:0]   bpipe_d [ADC_LAT];

    logic [ADDR_W-1:0] xbar_addr_q, xbar_addr_d;
    logic [BIT_W-1:0]  bit_sel_q, bit_sel_d;
    logic              xbar_en_q, xbar_en_d;
    logic [OUT_P-1:0]  res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic start_ok;

    assign start_ok = (start_addr <= end_addr) && (32'(end_addr) < DEPTH);

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        bit_d      = bit_q;
        drain_d    = drain_q;
        acc_d      = acc_q;
        err_d      = 1'b0;

        if (vld_q[ADC_LAT-1]) begin
            acc_d = acc_q + (OUT_P'(adc_result) << bpipe_q[ADC_LAT-1]);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d    = ISSUE;
                        cur_addr_d = start_addr;
                        end_addr_d = end_addr;
                        bit_d      = '0;
                        acc_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bit_q == BIT_W'(SLICE_BITS - 1)) begin
                    state_d = DRAIN;
                    drain_d = LAT_W'(ADC_LAT - 1);
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = EMIT;
                end else begin
                    drain_d = drain_q - LAT_W'(1);
                end
            end
            EMIT: begin
                if (res_valid_q && res_ready) begin
                    if (cur_addr_q != end_addr_q) begin
                        state_d    = ISSUE;
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        bit_d      = '0;
                        acc_d      = '0;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vld_d[0]   = xbar_en_q;
        bpipe_d[0] = bit_sel_q;
        for (int unsigned i = 1; i < ADC_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            bpipe_d[i] = bpipe_q[i-1];
        end

        xbar_en_d   = (state_d == ISSUE);
        xbar_addr_d = cur_addr_d;
        bit_sel_d   = (state_d == ISSUE) ? bit_d : '0;
        res_valid_d = (state_d == EMIT);
        res_data_d  = (state_d == EMIT) ? acc_d : '0;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            end_addr_q  <= '0;
            bit_q       <= '0;
            drain_q     <= '0;
            acc_q       <= '0;
            vld_q       <= '0;
            bpipe_q     <= '{default: '0};
            xbar_addr_q <= '0;
            bit_sel_q   <= '0;
            xbar_en_q   <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            end_addr_q  <= end_addr_d;
            bit_q       <= bit_d;
            drain_q     <= drain_d;
            acc_q       <= acc_d;
            vld_q       <= vld_d;
            bpipe_q     <= bpipe_d;
            xbar_addr_q <= xbar_addr_d;
            bit_sel_q   <= bit_sel_d;
            xbar_en_q   <= xbar_en_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign xbar_addr = xbar_addr_q;
    assign bit_sel   = bit_sel_q;
    assign xbar_en   = xbar_en_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pim_gemm_sched.sv
// Bench for pim_gemm_sched: a weight-table crossbar model feeds the ADC, and every column
// result is compared against the plain shift-and-add sum of that column's weights.
module tb_pim_gemm_sched;

    localparam int unsigned DEPTH      = 100;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned SLICE_BITS = 8;
    localparam int unsigned ADC_P      = 8;
    localparam int unsigned OUT_P      = 16;
    localparam int unsigned ADC_LAT    = 1;
    localparam int unsigned BIT_W      = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] xbar_addr;
    logic [BIT_W-1:0]  bit_sel;
    logic              xbar_en;
    logic [ADC_P-1:0]  adc_result;
    logic [OUT_P-1:0]  res_data;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic              err;

    pim_gemm_sched #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .SLICE_BITS(SLICE_BITS),
        .ADC_P     (ADC_P),
        .OUT_P     (OUT_P),
        .ADC_LAT   (ADC_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .end_addr  (end_addr),
        .xbar_addr (xbar_addr),
        .bit_sel   (bit_sel),
        .xbar_en   (xbar_en),
        .adc_result(adc_result),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Crossbar model: one ADC value per (column, input bit)
    logic [ADC_P-1:0] w [DEPTH][SLICE_BITS];
    logic [ADC_P-1:0] adc_line [ADC_LAT];

    // Expectation state shared between the sequencer and the monitor
    bit pass_active = 1'b0;
    bit done_due    = 1'b0;
    bit after_done  = 1'b0;
    bit reissue_due = 1'b0;
    bit prev_stall  = 1'b0;
    bit err_window  = 1'b0;
    int exp_col, exp_end, exp_bit, hs_count;
    int start_cyc, done_cyc;
    int fixed_exp  = -1;
    int rdy_mode   = 0;
    int stall_left = 0;
    int valid_run  = 0;
    int first_run  = -1;
    logic [OUT_P-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int col_expect(input int a);
        int sum = 0;
        for (int b = 0; b < SLICE_BITS; b++) sum += int'(w[a][b]) << b;
        return sum;
    endfunction

    task automatic fill_w(input bit rnd, input int cval);
        for (int a = 0; a < DEPTH; a++)
            for (int b = 0; b < SLICE_BITS; b++)
                w[a][b] = rnd ? ADC_P'($urandom) : ADC_P'(cval);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_xbar_en"},   xbar_en,   0);
        check({tag, "_xbar_addr"}, xbar_addr, 0);
        check({tag, "_bit_sel"},   bit_sel,   0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_err"},       err,       0);
    endtask

    task automatic clear_expect();
        pass_active = 1'b0;
        done_due    = 1'b0;
        after_done  = 1'b0;
        reissue_due = 1'b0;
        prev_stall  = 1'b0;
        valid_run   = 0;
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
        clear_expect();
        rst = 1'b1;
    endtask

    task automatic poke_start(input int s, input int e);
        @(posedge clk); #1;
        start_addr = ADDR_W'(s);
        end_addr   = ADDR_W'(e);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_start(input int s, input int e);
        @(posedge clk); #1;
        start_addr  = ADDR_W'(s);
        end_addr    = ADDR_W'(e);
        start       = 1'b1;
        start_cyc   = cyc;
        done_cyc    = -1;
        exp_col     = s;
        exp_end     = e;
        exp_bit     = 0;
        hs_count    = 0;
        first_run   = -1;
        valid_run   = 0;
        prev_stall  = 1'b0;
        pass_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_pass(input int budget);
        for (int i = 0; i < budget && pass_active; i++) begin
            @(posedge clk); #1;
        end
        if (pass_active) begin
            check("pass_timeout", pass_active, 0);
            apply_reset(2);
        end
    endtask

    task automatic run_pass(input int s, input int e, input int budget);
        do_start(s, e);
        wait_pass(budget);
        check("hs_count", hs_count, e - s + 1);
    endtask

    task automatic do_reject(input int s, input int e);
        err_window = 1'b1;
        poke_start(s, e);
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_xbar_en", xbar_en, 0);
        @(posedge clk); #1;
        check("rej_err_once", err, 0);
        repeat (4) begin @(posedge clk); #1; end
        err_window = 1'b0;
    endtask

    // Monitor: crossbar/ADC model, ready generation and all cycle-level checks
    initial begin
        bit r;
        logic [63:0] expv;
        res_ready  = 1'b1;
        adc_result = '0;
        for (int i = 0; i < ADC_LAT; i++) adc_line[i] = '0;
        forever begin
            @(negedge clk);
            adc_result = adc_line[ADC_LAT-1];
            for (int i = ADC_LAT - 1; i > 0; i--) adc_line[i] = adc_line[i-1];
            adc_line[0] = (xbar_en && (32'(xbar_addr) < DEPTH)) ? w[xbar_addr][bit_sel]
                                                                : ADC_P'($urandom);

            if (done_due) begin
                check("done_pulse", done, 1);
                done_due   = 1'b0;
                after_done = 1'b1;
                done_cyc   = cyc;
                pass_active = 1'b0;
            end else begin
                if (after_done) begin
                    check("busy_after_done", busy, 0);
                    after_done = 1'b0;
                end
                check("done_spur", done, 0);
            end

            if (!err_window) check("err_spur", err, 0);

            if (reissue_due) begin
                check("reissue_next_cycle", xbar_en, 1);
                reissue_due = 1'b0;
            end

            if (xbar_en) begin
                if (!pass_active || res_valid) begin
                    check("issue_spur", xbar_en, 0);
                end else begin
                    check("issue_addr", xbar_addr, exp_col);
                    check("issue_bit", bit_sel, exp_bit);
                    exp_bit++;
                end
            end

            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 2) != 0);
                default: r = !(res_valid && stall_left > 0);
            endcase
            if (rdy_mode == 2 && res_valid && stall_left > 0) stall_left--;
            res_ready = r;

            if (res_valid) begin
                if (!pass_active) check("valid_spur", res_valid, 0);
                if (prev_stall) check("hold_data", res_data, prev_data);
                valid_run++;
                if (r && pass_active) begin
                    expv = (fixed_exp >= 0) ? 64'(fixed_exp)
                         : ((exp_col < DEPTH) ? 64'(col_expect(exp_col)) : 64'hFFFF_FFFF);
                    check("res_data", res_data, expv);
                    check("issues_per_col", exp_bit, SLICE_BITS);
                    hs_count++;
                    if (first_run < 0) first_run = valid_run;
                    valid_run = 0;
                    if (exp_col == exp_end) begin
                        done_due = 1'b1;
                    end else begin
                        exp_col++;
                        exp_bit     = 0;
                        reissue_due = 1'b1;
                    end
                end
                prev_stall = !r;
                prev_data  = res_data;
            end else begin
                if (prev_stall) check("hold_valid", res_valid, 1);
                prev_stall = 1'b0;
                valid_run  = 0;
            end
        end
    end

    // Sequencer
    initial begin
        int s, e, found;
        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        fill_w(1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Single column, constant 1: all-ones slice sum and start-to-done latency
        fill_w(1'b0, 1);
        fixed_exp = 255;
        rdy_mode  = 0;
        run_pass(3, 3, 60);
        check("single_latency", done_cyc - start_cyc, SLICE_BITS + ADC_LAT + 2);

        // Single column, full-scale ADC
        fill_w(1'b0, 255);
        fixed_exp = 65025;
        run_pass(9, 9, 60);
        fixed_exp = -1;

        // Backpressure on the first of two columns
        fill_w(1'b1, 0);
        rdy_mode   = 2;
        stall_left = 5;
        run_pass(0, 1, 100);
        check("bp_valid_cycles", first_run, 6);
        rdy_mode = 0;

        // Rejected starts
        do_reject(10, 5);
        do_reject(3, 100);

        // Last column alone
        fill_w(1'b1, 0);
        run_pass(DEPTH - 1, DEPTH - 1, 60);

        // Starts while busy are ignored
        fill_w(1'b1, 0);
        rdy_mode = 1;
        do_start(5, 8);
        repeat (3) begin @(posedge clk); #1; end
        poke_start(10, 5);
        repeat (12) begin @(posedge clk); #1; end
        poke_start(0, 0);
        wait_pass(300);
        check("busy_start_hs", hs_count, 4);

        // Randomized passes with random backpressure
        for (int k = 0; k < 8; k++) begin
            fill_w(1'b1, 0);
            s = $urandom_range(0, DEPTH - 1);
            e = s + $urandom_range(0, 5);
            if (e > DEPTH - 1) e = DEPTH - 1;
            run_pass(s, e, (e - s + 1) * 60 + 50);
        end

        // Full address range
        fill_w(1'b1, 0);
        rdy_mode = 0;
        run_pass(0, DEPTH - 1, DEPTH * 12 + 50);

        // Reset in the middle of column 2, bit 4
        fill_w(1'b1, 0);
        do_start(0, 3);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(posedge clk); #1;
            if (xbar_en && xbar_addr == 2 && bit_sel == 4) found = 1;
        end
        check("rst_target_found", found, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_expect();
        check_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        check("post_reset_busy", busy, 0);
        fill_w(1'b1, 0);
        run_pass(7, 7, 60);
        check("post_reset_latency", done_cyc - start_cyc, SLICE_BITS + ADC_LAT + 2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
